// File: rtl/sram_responder.sv
// Memory-side responder for the CPU's active-low SRAM strobe interface. It returns reads after
// READ_LAT consecutive OE-low cycles and commits byte-masked writes when WE is released.
module sram_responder #(
    parameter int ADDR_W   = 16,
    parameter int DEPTH_W  = 10,
    parameter int DATA_W   = 16,
    parameter int READ_LAT = 2
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Mem_CE,
    input  logic              Mem_UB,
    input  logic              Mem_LB,
    input  logic              Mem_OE,
    input  logic              Mem_WE,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] Data_from_CPU,
    output logic [DATA_W-1:0] Data_to_CPU,
    output logic              Data_valid,
    output logic              Busy,
    output logic              Protocol_err
);
    localparam int         HALF = DATA_W / 2;
    localparam logic [2:0] LAT  = 3'(READ_LAT);

    typedef enum logic [2:0] {IDLE, READ, HOLD, WRITE, COMMIT} state_t;
    state_t state, state_d;

    logic [DATA_W-1:0]  mem [2**DEPTH_W];

    logic [2:0]         cnt, cnt_d;
    logic [DEPTH_W-1:0] rd_addr, wr_addr, held_addr, addr_idx;
    logic [DATA_W-1:0]  wr_data;
    logic               wr_ub, wr_lb, held_ub, held_lb, held_live;
    logic               sel, rd_req, wr_req, same_addr, do_commit;
    logic               latch_rd, latch_wr, load_data, valid_d, start_rd;
    logic [DATA_W-1:0]  stored_word, commit_word, array_word, read_word, refresh_word;
    logic               unused_addr_hi;

    assign sel            = ~Mem_CE;
    assign rd_req         = sel & ~Mem_OE & Mem_WE;
    assign wr_req         = sel & ~Mem_WE;
    assign addr_idx       = ADDR[DEPTH_W-1:0];
    assign unused_addr_hi = ^ADDR[ADDR_W-1:DEPTH_W];
    assign same_addr      = (addr_idx == rd_addr);
    assign do_commit      = (state == COMMIT);
    assign Busy           = (state != IDLE);

    // Lanes whose strobe was high at the last write cycle keep their stored contents.
    assign stored_word = mem[wr_addr];
    assign commit_word = {(wr_ub ? stored_word[DATA_W-1:HALF] : wr_data[DATA_W-1:HALF]),
                          (wr_lb ? stored_word[HALF-1:0]      : wr_data[HALF-1:0])};
    // A commit landing on this edge is forwarded so a read loading the same word sees it.
    assign array_word  = (do_commit && wr_addr == addr_idx) ? commit_word : mem[addr_idx];
    assign read_word   = {(Mem_UB ? {HALF{1'b0}} : array_word[DATA_W-1:HALF]),
                          (Mem_LB ? {HALF{1'b0}} : array_word[HALF-1:0])};
    assign refresh_word = {(held_ub ? {HALF{1'b0}} : commit_word[DATA_W-1:HALF]),
                           (held_lb ? {HALF{1'b0}} : commit_word[HALF-1:0])};

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_d;
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        latch_rd  = 1'b0;
        latch_wr  = 1'b0;
        load_data = 1'b0;
        valid_d   = 1'b0;
        start_rd  = 1'b0;
        case (state)
            IDLE: begin
                if (wr_req) begin
                    latch_wr = 1'b1;
                    state_d  = WRITE;
                end else if (rd_req) begin
                    start_rd = 1'b1;
                end
            end
            READ: begin
                if (wr_req) begin
                    latch_wr = 1'b1;
                    state_d  = WRITE;
                end else if (rd_req && same_addr) begin
                    cnt_d = cnt + 3'd1;
                    if (cnt + 3'd1 == LAT) begin
                        load_data = 1'b1;
                        valid_d   = 1'b1;
                        state_d   = HOLD;
                    end
                end else if (rd_req) begin
                    start_rd = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (wr_req) begin
                    latch_wr = 1'b1;
                    state_d  = WRITE;
                end else if (rd_req && same_addr) begin
                    valid_d = 1'b1;
                end else if (rd_req) begin
                    start_rd = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                if (wr_req) latch_wr = 1'b1;
                else        state_d  = COMMIT;
            end
            COMMIT: begin
                if (wr_req) begin
                    latch_wr = 1'b1;
                    state_d  = WRITE;
                end else if (rd_req) begin
                    start_rd = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // The cycle that starts a read is its first OE-low cycle; a one-cycle latency loads at once.
        if (start_rd) begin
            latch_rd = 1'b1;
            cnt_d    = 3'd1;
            if (LAT == 3'd1) begin
                load_data = 1'b1;
                valid_d   = 1'b1;
                state_d   = HOLD;
            end else begin
                state_d = READ;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt          <= 3'd0;
            rd_addr      <= '0;
            wr_addr      <= '0;
            wr_data      <= '0;
            wr_ub        <= 1'b1;
            wr_lb        <= 1'b1;
            held_addr    <= '0;
            held_ub      <= 1'b1;
            held_lb      <= 1'b1;
            held_live    <= 1'b0;
            Data_to_CPU  <= '0;
            Data_valid   <= 1'b0;
            Protocol_err <= 1'b0;
        end else begin
            cnt        <= cnt_d;
            Data_valid <= valid_d;
            if (sel && !Mem_OE && !Mem_WE) Protocol_err <= 1'b1;
            if (latch_rd) rd_addr <= addr_idx;
            if (latch_wr) begin
                wr_addr <= addr_idx;
                wr_data <= Data_from_CPU;
                wr_ub   <= Mem_UB;
                wr_lb   <= Mem_LB;
            end
            if (load_data) begin
                Data_to_CPU <= read_word;
                held_addr   <= addr_idx;
                held_ub     <= Mem_UB;
                held_lb     <= Mem_LB;
                held_live   <= 1'b1;
            end else begin
                if (latch_rd) held_live <= 1'b0;
                if (do_commit && held_live && wr_addr == held_addr) Data_to_CPU <= refresh_word;
            end
        end
    end

    // The array is deliberately left out of reset so its contents survive a Reset_n pulse.
    always_ff @(posedge Clk) begin
        if (do_commit) mem[wr_addr] <= commit_word;
    end

endmodule

// File: tb/tb_sram_responder.sv
// Scoreboard bench for sram_responder: a reference word model predicts each read, and the
// prediction is queued when the read is driven and compared when Data_valid rises.
module tb_sram_responder;
    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;
    logic [15:0] ADDR;
    logic [15:0] Data_from_CPU;
    logic [15:0] Data_to_CPU;
    logic        Data_valid, Busy, Protocol_err;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] model [1024];
    logic [15:0] expect_q [$];
    logic [15:0] last_data;

    always #5 Clk = ~Clk;

    sram_responder #(.ADDR_W(16), .DEPTH_W(10), .DATA_W(16), .READ_LAT(2)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB),
        .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .ADDR(ADDR), .Data_from_CPU(Data_from_CPU),
        .Data_to_CPU(Data_to_CPU), .Data_valid(Data_valid), .Busy(Busy),
        .Protocol_err(Protocol_err)
    );

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic bus_idle();
        Mem_CE = 1'b1; Mem_OE = 1'b1; Mem_WE = 1'b1; Mem_UB = 1'b0; Mem_LB = 1'b0;
    endtask

    task automatic model_write(input logic [15:0] addr, input logic [15:0] data,
                               input logic ub, input logic lb);
        logic [9:0] idx;
        idx = addr[9:0];
        if (!ub) model[idx][15:8] = data[15:8];
        if (!lb) model[idx][7:0]  = data[7:0];
    endtask

    // Earlier WE-low cycles carry inverted data so only the last cycle's value may land.
    task automatic write_word(input logic [15:0] addr, input logic [15:0] data, input logic ub,
                              input logic lb, input int n_cycles, input logic oe);
        Mem_CE = 1'b0; Mem_WE = 1'b0; Mem_OE = oe; Mem_UB = ub; Mem_LB = lb; ADDR = addr;
        for (int i = 0; i < n_cycles; i++) begin
            Data_from_CPU = (i == n_cycles - 1) ? data : ~data;
            tick();
        end
        model_write(addr, data, ub, lb);
        bus_idle();
        tick();
        tick();
    endtask

    task automatic start_read(input logic [15:0] addr, input logic ub, input logic lb);
        logic [15:0] w;
        w = model[addr[9:0]];
        expect_q.push_back({(ub ? 8'h00 : w[15:8]), (lb ? 8'h00 : w[7:0])});
        Mem_CE = 1'b0; Mem_OE = 1'b0; Mem_WE = 1'b1; Mem_UB = ub; Mem_LB = lb; ADDR = addr;
    endtask

    task automatic wait_valid(input string tag, input int exp_lat);
        int          n;
        logic [15:0] exp_word;
        n = 0;
        do begin
            tick();
            n++;
        end while (!Data_valid && n < 16);
        exp_word = (expect_q.size() > 0) ? expect_q.pop_front() : 16'hxxxx;
        if (!Data_valid) begin
            check_output({tag, " timeout"}, 32'd0, 32'd1);
        end else begin
            check_output({tag, " latency"}, n, exp_lat);
            check_output({tag, " data"}, Data_to_CPU, exp_word);
            last_data = exp_word;
        end
    endtask

    task automatic end_read(input string tag);
        bus_idle();
        tick();
        check_output({tag, " valid drop"}, Data_valid, 1'b0);
        check_output({tag, " data held"}, Data_to_CPU, last_data);
        tick();
        check_output({tag, " idle"}, Busy, 1'b0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus_idle();
        ADDR = 16'h0; Data_from_CPU = 16'h0; Reset_n = 1'b0; last_data = 16'h0;
        repeat (3) tick();
        check_output("reset data", Data_to_CPU, 16'h0);
        check_output("reset valid", Data_valid, 1'b0);
        check_output("reset busy", Busy, 1'b0);
        check_output("reset perr", Protocol_err, 1'b0);
        Reset_n = 1'b1;
        tick();

        // Full write with WE low two cycles, then a two-cycle OE read.
        write_word(16'h0010, 16'hBEEF, 1'b0, 1'b0, 2, 1'b1);
        start_read(16'h0010, 1'b0, 1'b0);
        wait_valid("t2 read", 2);
        end_read("t2");

        // Upper lane masked on write, then lower lane masked on read.
        write_word(16'h0020, 16'h1234, 1'b0, 1'b0, 1, 1'b1);
        write_word(16'h0020, 16'hABCD, 1'b1, 1'b0, 1, 1'b1);
        start_read(16'h0020, 1'b0, 1'b0);
        wait_valid("t3 read", 2);
        end_read("t3a");
        start_read(16'h0020, 1'b0, 1'b1);
        wait_valid("t3 lb masked", 2);
        end_read("t3b");

        // Address moves on the second OE-low cycle, restarting the latency count.
        write_word(16'h0011, 16'h7777, 1'b0, 1'b0, 1, 1'b1);
        Mem_CE = 1'b0; Mem_OE = 1'b0; Mem_WE = 1'b1; Mem_UB = 1'b0; Mem_LB = 1'b0;
        ADDR = 16'h0010;
        tick();
        check_output("t4 early valid", Data_valid, 1'b0);
        check_output("t4 busy", Busy, 1'b1);
        start_read(16'h0011, 1'b0, 1'b0);
        wait_valid("t4 moved addr", 2);
        end_read("t4");

        // Upper address bits alias onto the array.
        write_word(16'h0405, 16'h5555, 1'b0, 1'b0, 1, 1'b1);
        start_read(16'h0005, 1'b0, 1'b0);
        wait_valid("t6 alias", 2);
        end_read("t6a");

        // Read issued in the commit cycle must see the word just committed, not the old one.
        write_word(16'h0040, 16'h1111, 1'b0, 1'b0, 1, 1'b1);
        Mem_CE = 1'b0; Mem_WE = 1'b0; Mem_OE = 1'b1; Mem_UB = 1'b0; Mem_LB = 1'b0;
        ADDR = 16'h0040; Data_from_CPU = 16'h6666;
        tick();
        model_write(16'h0040, 16'h6666, 1'b0, 1'b0);
        bus_idle();
        tick();
        check_output("t6 commit busy", Busy, 1'b1);
        start_read(16'h0040, 1'b0, 1'b0);
        wait_valid("t6 back-to-back", 2);
        end_read("t6b");

        // OE and WE both low still writes but raises the sticky error; WE without CE does nothing.
        write_word(16'h0030, 16'h0F0F, 1'b0, 1'b0, 2, 1'b0);
        check_output("t5 perr set", Protocol_err, 1'b1);
        Mem_CE = 1'b1; Mem_WE = 1'b0; Mem_OE = 1'b1; ADDR = 16'h0030; Data_from_CPU = 16'hFFFF;
        repeat (3) tick();
        check_output("t5 deselected busy", Busy, 1'b0);
        bus_idle();
        tick();
        start_read(16'h0030, 1'b0, 1'b0);
        wait_valid("t5 no write", 2);
        end_read("t5");
        check_output("t5 perr sticky", Protocol_err, 1'b1);

        // Asynchronous reset in the middle of a read.
        Mem_CE = 1'b0; Mem_OE = 1'b0; Mem_WE = 1'b1; ADDR = 16'h0010;
        tick();
        check_output("t1 in read", Busy, 1'b1);
        Reset_n = 1'b0;
        #1;
        check_output("t1 async data", Data_to_CPU, 16'h0);
        check_output("t1 async valid", Data_valid, 1'b0);
        check_output("t1 async busy", Busy, 1'b0);
        check_output("t1 async perr", Protocol_err, 1'b0);
        bus_idle();
        tick();
        Reset_n = 1'b1;
        tick();
        tick();
        check_output("t1 post busy", Busy, 1'b0);
        check_output("t1 post valid", Data_valid, 1'b0);
        check_output("t1 post data", Data_to_CPU, 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
